motor_pwm_driver: RTL and testbench



---
 rtl/motor_pwm_driver.sv | 132 +++++++++++++
 tb/tb_motor_pwm_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
//
// Servo PWM driver for one wheel. It owns the period timebase, samples the
// controller's motor command once per period (in the last cycle) and drives
// one servo pulse per period at the start of that period. Because commands
// are only taken at the period boundary, a command change can never cut a
// pulse short or stretch it.
//
// Ports:
//   clk                system clock
//   reset              synchronous, active-high reset
//   i_motor_reset      1 = no pulse in the next period
//   i_motor_direction  1 = PULSE_FWD, 0 = PULSE_REV (before INVERT_DIR)
//   o_pwm              registered servo drive signal
//   o_count_out        current period counter value
//   o_period_start     one-cycle strobe at count 0, never while in IDLE
//   o_active           1 while the current period carries a latched run command
//   o_dbg_state        FSM state (0 = IDLE, 1 = HIGH, 2 = LOW)
//
// Handshake: there is none. The command inputs are level signals with no
// valid/ready pair; they are sampled only in the cycle where the counter is
// at PERIOD_CYCLES-1, and their value in any other cycle is ignored.
// -----------------------------------------------------------------------------
module motor_pwm_driver #(
  parameter int CNT_W         = 21,
  parameter int PERIOD_CYCLES = 2000000,
  parameter int PULSE_FWD     = 200000,
  parameter int PULSE_REV     = 100000,
  parameter int INVERT_DIR    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_motor_reset,
  input  logic             i_motor_direction,
  output logic             o_pwm,
  output logic [CNT_W-1:0] o_count_out,
  output logic             o_period_start,
  output logic             o_active,
  output logic [1:0]       o_dbg_state
);

  // Elaboration-time sanity on the timing parameters.
  if (!(PULSE_REV > 0 && PULSE_FWD > 0 &&
        PULSE_REV < PERIOD_CYCLES && PULSE_FWD < PERIOD_CYCLES &&
        64'(PERIOD_CYCLES) <= (64'd1 << CNT_W))) begin : g_param_check
    $error("motor_pwm_driver: illegal PERIOD_CYCLES/PULSE_FWD/PULSE_REV/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_FWD  = CNT_W'(PULSE_FWD);
  localparam logic [CNT_W-1:0] LP_REV  = CNT_W'(PULSE_REV);
  localparam logic             LP_INV  = (INVERT_DIR != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_width;
  logic             r_run;
  logic             r_pwm;

  logic             w_wrap;
  logic             w_run;
  logic             w_dir_eff;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] w_width_last;

  // Sample point is the last cycle of the period; the sample is loaded on the
  // wrap edge so it governs the whole of the following period.
  assign w_wrap       = (r_cnt == LP_LAST);
  assign w_run        = ~i_motor_reset;
  assign w_dir_eff    = i_motor_direction ^ LP_INV;
  assign w_width      = w_dir_eff ? LP_FWD : LP_REV;
  // Latched width is never 0 outside IDLE, so this cannot underflow where used.
  assign w_width_last = r_width - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_pwm   <= 1'b0;
      r_run   <= 1'b0;
      r_width <= '0;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_state <= w_next_state;
      // pwm follows the next state on the same edge as the counter, so its
      // value in the cycle with count k matches the state in that cycle.
      r_pwm   <= (w_next_state == S_HIGH);
      if (w_wrap) begin
        r_run   <= w_run;
        r_width <= w_width;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wrap) begin
          w_next_state = w_run ? S_HIGH : S_LOW;
        end
      end
      S_HIGH: begin
        // Width is always below the period, so HIGH ends before the wrap.
        if (r_cnt == w_width_last) begin
          w_next_state = S_LOW;
        end
      end
      S_LOW: begin
        if (w_wrap && w_run) begin
          w_next_state = S_HIGH;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_pwm          = r_pwm;
  assign o_count_out    = r_cnt;
  assign o_period_start = (r_cnt == '0) && (r_state != S_IDLE);
  assign o_active       = r_run && (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_motor_pwm_driver.sv
module tb_motor_pwm_driver;

  localparam int P    = 20;
  localparam int FWD  = 4;
  localparam int REV  = 2;
  localparam int CW   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic motor_reset;
  logic motor_direction;

  always #5 clk = ~clk;

  // Normal instance and mirror-mounted instance share the command inputs.
  logic          pwm_n, ps_n, act_n;
  logic [CW-1:0] cnt_n;
  logic [1:0]    st_n;
  logic          pwm_i, ps_i, act_i;
  logic [CW-1:0] cnt_i;
  logic [1:0]    st_i;

  motor_pwm_driver #(.CNT_W(CW), .PERIOD_CYCLES(P), .PULSE_FWD(FWD),
                     .PULSE_REV(REV), .INVERT_DIR(0)) dut_n (
    .clk(clk), .reset(reset),
    .i_motor_reset(motor_reset), .i_motor_direction(motor_direction),
    .o_pwm(pwm_n), .o_count_out(cnt_n), .o_period_start(ps_n),
    .o_active(act_n), .o_dbg_state(st_n));

  motor_pwm_driver #(.CNT_W(CW), .PERIOD_CYCLES(P), .PULSE_FWD(FWD),
                     .PULSE_REV(REV), .INVERT_DIR(1)) dut_i (
    .clk(clk), .reset(reset),
    .i_motor_reset(motor_reset), .i_motor_direction(motor_direction),
    .o_pwm(pwm_i), .o_count_out(cnt_i), .o_period_start(ps_i),
    .o_active(act_i), .o_dbg_state(st_i));

  // ---------------- reference model ----------------
  // Cycles elapsed since reset release; the period index and position follow
  // by plain arithmetic. Each period obeys the command seen in the last
  // cycle of the previous period; the first period after reset emits nothing.
  int m_since;
  bit m_started;
  bit m_run;
  int m_w_n;
  int m_w_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int c;
    c = m_since % P;
    chk("cnt_n", 32'(cnt_n), 32'(c));
    chk("cnt_i", 32'(cnt_i), 32'(c));
    chk("pwm_n", 32'(pwm_n), 32'(m_started && m_run && (c < m_w_n)));
    chk("pwm_i", 32'(pwm_i), 32'(m_started && m_run && (c < m_w_i)));
    chk("ps_n",  32'(ps_n),  32'(m_started && (c == 0)));
    chk("ps_i",  32'(ps_i),  32'(m_started && (c == 0)));
    chk("act_n", 32'(act_n), 32'(m_started && m_run));
    chk("act_i", 32'(act_i), 32'(m_started && m_run));
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare all outputs a little after the edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_since   = 0;
      m_started = 0;
      m_run     = 0;
    end else begin
      if (m_since % P == P - 1) begin
        m_started = 1;
        m_run     = !motor_reset;
        m_w_n     = motor_direction ? FWD : REV;
        m_w_i     = motor_direction ? REV : FWD;
      end
      m_since++;
    end
    #1;
    check_outputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model position equals k (bounded by one period).
  task automatic goto_cnt(input int k);
    for (int i = 0; i < P && (m_since % P) != k; i++) step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_since = 0; m_started = 0; m_run = 0; m_w_n = 0; m_w_i = 0;
    reset = 1'b1;
    motor_reset = 1'b0;
    motor_direction = 1'b1;

    // Reset state.
    run_cycles(3);
    reset = 1'b0;

    // Run forward: first period silent, then 4-cycle pulses (2 mirrored).
    run_cycles(3 * P);

    // Reverse held.
    motor_direction = 1'b0;
    run_cycles(2 * P);

    // Direction toggled mid-pulse: current pulse keeps its width.
    motor_direction = 1'b1;
    goto_cnt(0);
    run_cycles(P);
    goto_cnt(2);
    motor_direction = 1'b0;
    run_cycles(2 * P);

    // Stop sampled at cnt=19, then run restored before the next sample.
    motor_direction = 1'b1;
    goto_cnt(P - 1);
    motor_reset = 1'b1;
    step();
    motor_reset = 1'b0;
    run_cycles(2 * P);

    // Random commands changing at random cycles.
    for (int i = 0; i < 12 * P; i++) begin
      if ($urandom_range(0, 3) == 0) motor_reset = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) motor_direction = 1'($urandom_range(0, 1));
      step();
    end

    // Reset asserted during a HIGH pulse.
    motor_reset = 1'b0;
    motor_direction = 1'b1;
    goto_cnt(P - 1);
    step();
    goto_cnt(2);
    chk("pwm_before_reset", 32'(pwm_n), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("pwm_after_reset", 32'(pwm_n), 32'd0);
    chk("ps_after_reset", 32'(ps_n), 32'd0);
    run_cycles(3 * P);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
